// File: rtl/control_unit.sv
// Sequencer for the matrix-multiplier core: IDLE -> FETCH -> DECODE -> EXEC loop, HALT on 0xFF.
// Outputs are decoded from the registered state and ir (plus z during JPNZ EXEC).
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ir,
  input  logic        z,
  output logic        end_op,
  output logic [1:0]  inc,
  output logic [3:0]  alu_mode,
  output logic [3:0]  bus_ld,
  output logic [12:0] write_en,
  output logic [2:0]  clr,
  output logic        dm_wr,
  output logic        im_wr
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
  } state_e;

  localparam logic [3:0] BUS_DM   = 4'd0;
  localparam logic [3:0] BUS_AC   = 4'd5;
  localparam logic [3:0] BUS_IM   = 4'd14;
  localparam logic [3:0] BUS_NONE = 4'd15;

  state_e state_q, state_d;

  logic [3:0] fam, n;
  logic       n_ok;

  assign fam  = ir[7:4];
  assign n    = ir[3:0];
  assign n_ok = (n >= 4'd1) && (n <= 4'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    end_op   = 1'b0;
    inc      = 2'b00;
    alu_mode = 4'd0;
    bus_ld   = BUS_NONE;
    write_en = '0;
    clr      = 3'b000;
    dm_wr    = 1'b0;
    im_wr    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus_ld      = BUS_IM;
        write_en[0] = 1'b1;
        inc[0]      = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: state_d = (ir == 8'hFF) ? S_HALT : S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        if (fam == 4'h0) begin
          case (n)
            4'h1: begin bus_ld = BUS_DM; write_en[4] = 1'b1; end
            4'h2: begin bus_ld = BUS_AC; dm_wr = 1'b1; end
            4'h3: clr[0] = 1'b1;
            4'h4: inc[1] = 1'b1;
            4'h5: clr[1] = 1'b1;
            4'h6: begin bus_ld = BUS_AC; write_en[2] = 1'b1; end
            4'h7: begin bus_ld = BUS_IM; write_en[1] = 1'b1; end
            4'h8: begin
              // Taken branch loads PC from the operand; not taken skips the operand byte.
              if (!z) begin bus_ld = BUS_IM; write_en[1] = 1'b1; end
              else    inc[0] = 1'b1;
            end
            4'h9: begin bus_ld = BUS_IM; write_en[4] = 1'b1; inc[0] = 1'b1; end
            4'hA: begin bus_ld = BUS_AC; im_wr = 1'b1; end
            4'hB: clr[2] = 1'b1;
            default: ;
          endcase
        end else if (fam == 4'h1 && n_ok) begin
          bus_ld              = BUS_AC;
          write_en[4 + 32'(n)] = 1'b1;
        end else if (fam >= 4'h2 && fam <= 4'h5 && n_ok) begin
          // Register families 2..5 map to alu_mode PASS/ADD/SUB/MUL.
          bus_ld      = 4'd5 + n;
          alu_mode    = fam - 4'h2;
          write_en[4] = 1'b1;
        end
      end
      S_HALT: end_op = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random opcodes
// checked against a phase-level behavioural model of the instruction cycle.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ir;
  logic        z;
  logic        end_op;
  logic [1:0]  inc;
  logic [3:0]  alu_mode;
  logic [3:0]  bus_ld;
  logic [12:0] write_en;
  logic [2:0]  clr;
  logic        dm_wr;
  logic        im_wr;

  int checks = 0;
  int errors = 0;
  int ph;  // 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 HALT

  control_unit dut (
    .clk(clk), .rst(rst), .ir(ir), .z(z), .end_op(end_op), .inc(inc),
    .alu_mode(alu_mode), .bus_ld(bus_ld), .write_en(write_en), .clr(clr),
    .dm_wr(dm_wr), .im_wr(im_wr)
  );

  always #5 clk = ~clk;

  wire [28:0] act = {end_op, inc, alu_mode, bus_ld, write_en, clr, dm_wr, im_wr};
  localparam logic [28:0] DEF = {1'b0, 2'b0, 4'd0, 4'd15, 13'h0, 3'b0, 1'b0, 1'b0};

  function automatic logic [28:0] pack(logic e, logic [1:0] i, logic [3:0] am, logic [3:0] bl,
                                       logic [12:0] we, logic [2:0] c, logic d, logic m);
    return {e, i, am, bl, we, c, d, m};
  endfunction

  // Expected outputs from the instruction tables, phrased per phase/opcode.
  function automatic logic [28:0] model(int p, logic [7:0] op, logic zz);
    int hi, lo;
    logic e = 0; logic [1:0] i = 0; logic [3:0] am = 0; logic [3:0] bl = 15;
    logic [12:0] we = 0; logic [2:0] c = 0; logic d = 0; logic m = 0;
    hi = int'(op) / 16;
    lo = int'(op) % 16;
    if (p == 1) begin bl = 14; we = 13'd1; i = 2'd1; end
    else if (p == 4) e = 1;
    else if (p == 3) begin
      if (hi == 0) begin
        case (lo)
          1: begin bl = 0; we = 13'd16; end
          2: begin bl = 5; d = 1; end
          3: c = 3'd1;
          4: i = 2'd2;
          5: c = 3'd2;
          6: begin bl = 5; we = 13'd4; end
          7: begin bl = 14; we = 13'd2; end
          8: if (zz == 0) begin bl = 14; we = 13'd2; end else i = 2'd1;
          9: begin bl = 14; we = 13'd16; i = 2'd1; end
          10: begin bl = 5; m = 1; end
          11: c = 3'd4;
          default: ;
        endcase
      end else if (hi >= 1 && hi <= 5 && lo >= 1 && lo <= 7) begin
        if (hi == 1) begin bl = 5; we = 13'(1 << (4 + lo)); end
        else begin bl = 4'(5 + lo); we = 13'd16; am = 4'(hi - 2); end
      end
    end
    return pack(e, i, am, bl, we, c, d, m);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) ph = 0;
    else case (ph)
      0: ph = 1;
      1: ph = 2;
      2: ph = (ir == 8'hFF) ? 4 : 3;
      3: ph = 1;
      default: ph = 4;
    endcase
    #1;
  endtask

  // Runs one full instruction starting in FETCH; compares every phase against the model.
  task automatic run_instr(input logic [7:0] op, input logic zz, input string nm,
                           output logic [28:0] ex);
    ir = op; z = zz;
    ex = DEF;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act !== model(ph, ir, z) || $countones(write_en) > 1 || (dm_wr && im_wr)) begin
        errors++;
        $display("FAIL %s op=%02h phase=%0d: got %h expected %h", nm, op, ph, act, model(ph, ir, z));
      end
      if (ph == 3) ex = act;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1; ir = 8'h00; z = 0; ph = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act !== DEF) begin errors++; $display("FAIL reset_hold: got %h expected %h", act, DEF); end
    rst = 0;
    checks++;
    if (act !== DEF) begin errors++; $display("FAIL reset_idle: got %h expected %h", act, DEF); end
    tick();
    checks++;
    if (bus_ld !== 4'd14 || write_en !== 13'h0001 || inc !== 2'b01) begin
      errors++;
      $display("FAIL first_fetch: got bus=%0d we=%h inc=%b expected bus=14 we=0001 inc=01",
               bus_ld, write_en, inc);
    end
  endtask

  task automatic test_basic();
    logic [28:0] ex;
    run_instr(8'h01, 0, "ldac", ex);
    checks++;
    if (ex !== pack(0, 0, 0, 0, 13'h0010, 0, 0, 0)) begin errors++; $display("FAIL ldac_exec: got %h", ex); end
    run_instr(8'h02, 0, "stac", ex);
    checks++;
    if (ex !== pack(0, 0, 0, 5, 13'h0, 0, 1, 0)) begin errors++; $display("FAIL stac_exec: got %h", ex); end
    run_instr(8'h03, 0, "clac", ex);
    checks++;
    if (ex !== pack(0, 0, 0, 15, 13'h0, 3'b001, 0, 0)) begin errors++; $display("FAIL clac_exec: got %h", ex); end
    run_instr(8'h04, 0, "incar", ex);
    checks++;
    if (ex !== pack(0, 2'b10, 0, 15, 13'h0, 0, 0, 0)) begin errors++; $display("FAIL incar_exec: got %h", ex); end
  endtask

  task automatic test_alu();
    logic [28:0] ex;
    run_instr(8'h33, 0, "add_r3", ex);
    checks++;
    if (ex !== pack(0, 0, 4'd1, 4'd8, 13'h0010, 0, 0, 0)) begin errors++; $display("FAIL add_r3_exec: got %h", ex); end
    run_instr(8'h30, 0, "add_r0", ex);
    checks++;
    if (ex !== DEF) begin errors++; $display("FAIL add_r0_nop: got %h expected %h", ex, DEF); end
    run_instr(8'h38, 0, "add_r8", ex);
    checks++;
    if (ex !== DEF) begin errors++; $display("FAIL add_r8_nop: got %h expected %h", ex, DEF); end
    run_instr(8'h17, 0, "mvr_r7", ex);
    checks++;
    if (ex !== pack(0, 0, 0, 5, 13'h0800, 0, 0, 0)) begin errors++; $display("FAIL mvr_r7_exec: got %h", ex); end
  endtask

  task automatic test_jpnz();
    logic [28:0] ex;
    run_instr(8'h08, 0, "jpnz_z0", ex);
    checks++;
    if (ex !== pack(0, 0, 0, 14, 13'h0002, 0, 0, 0)) begin errors++; $display("FAIL jpnz_taken: got %h", ex); end
    run_instr(8'h08, 1, "jpnz_z1", ex);
    checks++;
    if (ex !== pack(0, 2'b01, 0, 15, 13'h0, 0, 0, 0)) begin errors++; $display("FAIL jpnz_skip: got %h", ex); end
  endtask

  task automatic test_unlisted();
    logic [28:0] ex;
    run_instr(8'hA7, 1, "unlisted", ex);
    checks++;
    if (ex !== DEF) begin errors++; $display("FAIL unlisted_exec: got %h expected %h", ex, DEF); end
    checks++;
    if (bus_ld !== 4'd14 || write_en !== 13'h0001) begin
      errors++; $display("FAIL unlisted_next_fetch: got bus=%0d we=%h", bus_ld, write_en);
    end
  endtask

  task automatic test_random();
    logic [28:0] ex;
    logic [7:0]  op;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 1)
        op = 8'($urandom_range(0, 5) * 16 + $urandom_range(0, 11));
      else
        op = 8'($urandom_range(0, 254));
      run_instr(op, 1'($urandom_range(0, 1)), "random", ex);
    end
  endtask

  task automatic test_reset_mid();
    ir = 8'h55; z = 0;
    tick();
    tick();
    checks++;
    if (ph != 3 || alu_mode !== 4'd3) begin errors++; $display("FAIL mid_exec_setup: alu_mode=%0d expected 3", alu_mode); end
    #2 rst = 1;
    ph = 0;
    #1;
    checks++;
    if (act !== DEF) begin errors++; $display("FAIL reset_async: got %h expected %h", act, DEF); end
    tick();
    rst = 0;
    tick();
    checks++;
    if (act !== model(1, ir, z)) begin errors++; $display("FAIL fetch_after_reset: got %h", act); end
  endtask

  task automatic test_halt();
    logic [28:0] hv;
    hv = pack(1, 0, 0, 15, 13'h0, 0, 0, 0);
    ir = 8'hFF;
    tick();
    tick();
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (act !== hv) begin errors++; $display("FAIL halt_hold cyc%0d: got %h expected %h", k, act, hv); end
      ir = 8'($urandom_range(0, 255));
      tick();
    end
    rst = 1;
    ph = 0;
    #1;
    checks++;
    if (act !== DEF) begin errors++; $display("FAIL halt_reset: got %h expected %h", act, DEF); end
    tick();
    rst = 0;
    checks++;
    if (act !== DEF) begin errors++; $display("FAIL halt_idle: got %h expected %h", act, DEF); end
    tick();
    checks++;
    if (act !== model(1, ir, z)) begin errors++; $display("FAIL halt_refetch: got %h", act); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alu();
    test_jpnz();
    test_unlisted();
    test_random();
    test_reset_mid();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Microprogrammed-style FSM sequencer for the single-core matrix-multiplier processor.
- Takes the current instruction byte (ir) and the ALU zero flag (z). Drives bus-source select, register write enables, increment/clear strobes, ALU mode, memory write strobes and program end.
- Moore outputs are decoded from the registered state and ir.

Parameters:
- None. Encodings below are fixed.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- ir  in  8  instruction register contents (opcode)
- z  in  1  ALU zero flag
- end_op  out  1  program finished (held high in HALT)
- inc  out  2  [0] PC+1, [1] AR+1
- alu_mode  out  4  0 PASS(bus), 1 ADD(AC+bus), 2 SUB(AC-bus), 3 MUL(AC*bus); other codes unused
- bus_ld  out  4  bus source: 0 DM, 1 IR, 2 PC, 3 AR, 4 DR, 5 AC, 6-12 R1-R7, 13 TR, 14 IM, 15 none
- write_en  out  13  one-hot register load: 0 IR, 1 PC, 2 AR, 3 DR, 4 AC, 5-11 R1-R7, 12 TR
- clr  out  3  [0] AC<-0, [1] AR<-0, [2] PC<-0
- dm_wr  out  1  data memory write, DM[AR]<-bus
- im_wr  out  1  instruction memory write, IM[AR]<-bus

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Default output set: write_en=0, inc=0, clr=0, dm_wr=0, im_wr=0, end_op=0, alu_mode=0, bus_ld=15. Any output not listed for a state takes its default.
- rst high: state=IDLE immediately, regardless of current state. Reset mid-instruction aborts the instruction.
- IDLE: default outputs. Next state FETCH.
- FETCH: bus_ld=14, write_en[0]=1, inc[0]=1. Next state DECODE.
- DECODE: default outputs; ir is now stable. Next state EXEC, or HALT if ir=0xFF.
- EXEC: one cycle, then FETCH. Outputs by opcode:
  - 0x00 NOP: defaults.
  - 0x01 LDAC: bus_ld=0, write_en[4].
  - 0x02 STAC: bus_ld=5, dm_wr=1.
  - 0x03 CLAC: clr[0]=1.
  - 0x04 INCAR: inc[1]=1.
  - 0x05 CLAR: clr[1]=1.
  - 0x06 LDAR: bus_ld=5, write_en[2].
  - 0x07 JMP: bus_ld=14, write_en[1] (PC<-IM[PC]).
  - 0x08 JPNZ: z=0 gives the JMP outputs; z=1 gives inc[0]=1 (skip operand byte).
  - 0x09 LDIM: bus_ld=14, write_en[4], inc[0]=1.
  - 0x0A STIM: bus_ld=5, im_wr=1.
  - 0x0B CLPC: clr[2]=1.
  - 0x1n MVR (AC->Rn): bus_ld=5, write_en[4+n].
  - 0x2n MVA (Rn->AC): bus_ld=5+n, write_en[4], alu_mode=0.
  - 0x3n ADD: bus_ld=5+n, alu_mode=1, write_en[4].
  - 0x4n SUB: bus_ld=5+n, alu_mode=2, write_en[4].
  - 0x5n MUL: bus_ld=5+n, alu_mode=3, write_en[4].
  - For families 0x1n-0x5n, n is valid for 1..7. Any other n, and any unlisted opcode, executes as NOP.
- HALT: end_op=1, all other outputs at defaults. Stays in HALT until rst.
- z is sampled only combinationally in EXEC of JPNZ.
- At most one write_en bit is high in any cycle.
- dm_wr and im_wr are never high together.
- Latency: 3 cycles per instruction (FETCH, DECODE, EXEC). The first FETCH occurs in the cycle after rst is released.

Test Plan:
- Reset: assert rst mid-EXEC -> all outputs at defaults (bus_ld=15, everything else 0) immediately. After release: IDLE, then FETCH outputs bus_ld=14, write_en=13'h0001, inc=2'b01.
- ir=0x01, 0x02, 0x03, 0x04 in successive instructions -> EXEC outputs in turn:
  - write_en=13'h0010 with bus_ld=0;
  - dm_wr=1 with bus_ld=5;
  - clr=3'b001;
  - inc=2'b10.
- ir=0x33 -> EXEC: bus_ld=8, alu_mode=1, write_en=13'h0010. ir=0x30 and ir=0x38 -> all EXEC outputs at defaults.
- ir=0x08 with z=0 -> EXEC: bus_ld=14, write_en=13'h0002. Same with z=1 -> inc=2'b01, write_en=0.
- ir=0xFF -> after DECODE, end_op=1 held for 10+ cycles with no writes. A pulse on rst returns the FSM to IDLE, then FETCH.
- Unlisted opcode (0xA7) -> EXEC outputs all at defaults; next FETCH follows normally.
